pdm_capture_controller: RTL
===========================

PDM_CAPTURE_CONTROLLER -- requirements
Module: pdm_capture_controller

Interface
REQ-001 Parameter ADDR_WIDTH, 10, capture-buffer address width.
REQ-002 Parameter MAX_WORDS, 1024, words per capture; legal range 1..2^ADDR_WIDTH.
REQ-003 Parameter TIMEOUT_CYCLES, 4096, max clock_i cycles in RUN without a new word before error; legal range ≥ 2.
REQ-004 clock_i  in  1  system clock, 100 MHz; sole clock.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 start_i  in  1  one-cycle start-capture request.
REQ-007 stop_i  in  1  one-cycle early-stop request.
REQ-008 deser_enable_o  out  1  enable to the PDM deserializer; low clears it.
REQ-009 deser_done_i  in  1  deserializer word-ready level.
REQ-010 deser_data_i  in  16  deserializer output word.
REQ-011 mem_we_o  out  1  buffer write strobe, one cycle per word.
REQ-012 mem_addr_o  out  ADDR_WIDTH  buffer write address.
REQ-013 mem_data_o  out  16  buffer write data.
REQ-014 busy_o  out  1  high in RUN or WRITE.
REQ-015 done_o  out  1  level; capture ended normally or by stop.
REQ-016 error_o  out  1  level; capture aborted by timeout.
REQ-017 word_count_o  out  ADDR_WIDTH+1  words written in current/last capture.

Function
REQ-018 States: IDLE, RUN, WRITE, DONE; all outputs registered.
REQ-019 IDLE/DONE: deser_enable_o=0, busy_o=0, mem_we_o=0.
REQ-020 start_i in IDLE or DONE: next state RUN; address, word_count_o, timeout counter to 0; done_o, error_o to 0.
REQ-021 start_i in RUN or WRITE ignored; stop_i in IDLE or DONE ignored.
REQ-022 RUN: deser_enable_o=1; a word is accepted only on a rising edge of deser_done_i (sampled 1, previous sample 0).
REQ-023 Edge-detect history set to 1 on RUN entry from IDLE/DONE/WRITE, so a stale high deser_done_i is not accepted until seen low.
REQ-024 Accepted word: deser_data_i registered same edge; next cycle state WRITE.
REQ-025 WRITE (exactly one cycle): mem_we_o=1, mem_addr_o=current address, mem_data_o=registered word, deser_enable_o=0 (re-arms deserializer).
REQ-026 Leaving WRITE: address and word_count_o increment by 1; if new count == MAX_WORDS or stop pending, go DONE with done_o=1; else RUN.
REQ-027 Address wraps never; MAX_WORDS ≤ 2^ADDR_WIDTH guarantees last address = MAX_WORDS-1.
REQ-028 stop_i in RUN: next state DONE, done_o=1, no write of partial word.
REQ-029 stop_i in WRITE: latched as pending; write completes, then DONE.
REQ-030 start_i and stop_i same cycle in RUN: stop wins.
REQ-031 Timeout counter: cleared on RUN entry and on word acceptance, increments each RUN cycle; reaching TIMEOUT_CYCLES: state DONE, error_o=1, done_o=0, no write.
REQ-032 Word acceptance and timeout in same cycle: acceptance wins.
REQ-033 Word acceptance and stop_i same cycle in RUN: stop wins, word discarded.
REQ-034 word_count_o holds its value in DONE until next start_i.
REQ-035 Latency: deser_done_i rising sample at edge N -> mem_we_o high during cycle N+1 -> count updated at edge N+2.

Reset
REQ-036 reset_i sampled high on clock_i edge: state IDLE; deser_enable_o, mem_we_o, busy_o, done_o, error_o = 0; mem_addr_o, mem_data_o, word_count_o, timeout counter, stop-pending = 0; edge history = 1.
REQ-037 reset_i has priority over all inputs, including mid-WRITE (write strobe dropped next cycle, no increment).

Verification
REQ-038 MAX_WORDS=4, start, deser model gives rising done with 0xA001..0xA004 -> 4 writes at addr 0..3, data in order, done_o=1, word_count_o=4, busy_o=0.
REQ-039 deser_done_i held high at start -> no write until it falls and rises again; deser_enable_o low exactly one cycle per write.
REQ-040 MAX_WORDS=8, stop_i in RUN after 3 words -> done_o=1, word_count_o=3, no further mem_we_o; stop_i in WRITE cycle of word 3 -> word 3 written, count 3.
REQ-041 TIMEOUT_CYCLES=16, deser_done_i stuck low -> 16 RUN cycles then error_o=1, done_o=0, word_count_o=0.
REQ-042 reset_i asserted during WRITE of word 2 -> next cycle all outputs at REQ-036 values; subsequent start captures from address 0.
REQ-043 start_i in DONE after error -> error_o=0, word_count_o=0, capture restarts at address 0.

Source files
------------

// File: rtl/pdm_capture_controller.sv
// Purpose: moves PDM deserializer words into a capture buffer, one write strobe per word.
// Latency: rising deser_done_i sampled at edge N -> mem_we_o high after edge N+1 -> count updated at edge N+2.
// Backpressure: none on the buffer side; the deserializer is re-armed by dropping deser_enable_o during each write.
module pdm_capture_controller #(
  parameter int ADDR_WIDTH     = 10,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  output logic                  deser_enable_o,
  input  logic                  deser_done_i,
  input  logic [15:0]           deser_data_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [15:0]           mem_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH:0]   word_count_o
);

  // The timeout counter only has to reach TIMEOUT_CYCLES-1 before the abort fires.
  localparam int                  TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] MAX_CNT  = (ADDR_WIDTH + 1)'(MAX_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_q,        state_d;
  logic                  deser_enable_q, deser_enable_d;
  logic                  mem_we_q,       mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,     mem_addr_d;
  logic [15:0]           mem_data_q,     mem_data_d;
  logic                  busy_q,         busy_d;
  logic                  done_q,         done_d;
  logic                  error_q,        error_d;
  logic [ADDR_WIDTH:0]   word_count_q,   word_count_d;
  logic [TMO_W-1:0]      tmo_q,          tmo_d;
  // Previous deser_done_i sample; forced high on RUN entry so a level left
  // high from before is not mistaken for a fresh word.
  logic                  done_hist_q,    done_hist_d;
  // A word was accepted at the last edge and its write is committed.
  logic                  word_pend_q,    word_pend_d;
  // Stop arrived after a word was committed; finish that write, then stop.
  logic                  stop_pend_q,    stop_pend_d;

  logic                  done_rise;
  logic [ADDR_WIDTH:0]   count_inc;

  assign done_rise = deser_done_i & ~done_hist_q;
  assign count_inc = word_count_q + 1'b1;

  // Next-state and registered-output computation for the capture sequencer.
  always_comb begin
    state_d        = state_q;
    deser_enable_d = deser_enable_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    busy_d         = busy_q;
    done_d         = done_q;
    error_d        = error_q;
    word_count_d   = word_count_q;
    tmo_d          = tmo_q;
    done_hist_d    = done_hist_q;
    word_pend_d    = word_pend_q;
    stop_pend_d    = stop_pend_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // stop_i means nothing here; only a start opens a new capture.
        if (start_i) begin
          state_d        = ST_RUN;
          deser_enable_d = 1'b1;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          error_d        = 1'b0;
          mem_addr_d     = '0;
          word_count_d   = '0;
          tmo_d          = '0;
          done_hist_d    = 1'b1;
          word_pend_d    = 1'b0;
          stop_pend_d    = 1'b0;
        end
      end

      ST_RUN: begin
        done_hist_d = deser_done_i;
        if (word_pend_q) begin
          // The word captured last edge is committed: write it now.
          state_d        = ST_WRITE;
          mem_we_d       = 1'b1;
          deser_enable_d = 1'b0;
          word_pend_d    = 1'b0;
          stop_pend_d    = stop_i;
        end else if (stop_i) begin
          // Stop beats a same-cycle word and a same-cycle timeout.
          state_d        = ST_DONE;
          deser_enable_d = 1'b0;
          busy_d         = 1'b0;
          done_d         = 1'b1;
        end else if (done_rise) begin
          // Acceptance beats a same-cycle timeout.
          mem_data_d  = deser_data_i;
          word_pend_d = 1'b1;
          tmo_d       = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d        = ST_DONE;
          deser_enable_d = 1'b0;
          busy_d         = 1'b0;
          done_d         = 1'b0;
          error_d        = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_WRITE: begin
        word_count_d = count_inc;
        // With MAX_WORDS <= 2^ADDR_WIDTH only the final write can sit at the
        // top address; hold there rather than wrap to 0.
        if (mem_addr_q != '1) begin
          mem_addr_d = mem_addr_q + 1'b1;
        end
        stop_pend_d = 1'b0;
        if ((count_inc == MAX_CNT) || stop_pend_q || stop_i) begin
          state_d        = ST_DONE;
          deser_enable_d = 1'b0;
          busy_d         = 1'b0;
          done_d         = 1'b1;
        end else begin
          state_d        = ST_RUN;
          deser_enable_d = 1'b1;
          tmo_d          = '0;
          done_hist_d    = 1'b1;
        end
      end

      default: begin
        state_d        = ST_IDLE;
        deser_enable_d = 1'b0;
        busy_d         = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides everything, including a write in flight.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      deser_enable_q <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      word_count_q   <= '0;
      tmo_q          <= '0;
      done_hist_q    <= 1'b1;
      word_pend_q    <= 1'b0;
      stop_pend_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      deser_enable_q <= deser_enable_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      word_count_q   <= word_count_d;
      tmo_q          <= tmo_d;
      done_hist_q    <= done_hist_d;
      word_pend_q    <= word_pend_d;
      stop_pend_q    <= stop_pend_d;
    end
  end

  assign deser_enable_o = deser_enable_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_data_o     = mem_data_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign word_count_o   = word_count_q;

endmodule
